otter_cu_fsm: RTL and testbench

OTTER_CU_FSM -- requirements
Module: otter_cu_fsm

---
 rtl/otter_cu_pkg.sv | 25 ++
 rtl/otter_cu_fsm_if.sv | 29 ++
 rtl/otter_cu_fsm.sv | 97 +++++++++
 tb/tb_otter_cu_fsm.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/otter_cu_pkg.sv
// otter_cu_pkg: shared state enum, opcode and SYSTEM func3 constants for the OTTER control unit and decoder
package otter_cu_pkg;
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
`ifdef CU_MEM_WAIT_EN
        , ST_MEM_WAIT = 3'd5
`endif
    } state_t;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [2:0] F3_MRET    = 3'b000;
    localparam logic [2:0] F3_CSRRW   = 3'b001;
endpackage

// File: rtl/otter_cu_fsm_if.sv
// otter_cu_fsm_if: control-unit bundle between the FSM and the datapath
//   master (FSM): reads IR_OPCODE, IR_FUNC3, INTR, CSR_MIE, MEM_RDY;
//                 drives PC_WRITE, REG_WRITE, MEM_WE2, MEM_RDEN1, MEM_RDEN2,
//                 CSR_WE, INT_TAKEN, ILLEGAL and the 3-bit debug STATE
//   slave (datapath): the mirror image
interface otter_cu_fsm_if;
    logic [6:0] IR_OPCODE;
    logic [2:0] IR_FUNC3;
    logic       INTR;
    logic       CSR_MIE;
    logic       MEM_RDY;
    logic       PC_WRITE;
    logic       REG_WRITE;
    logic       MEM_WE2;
    logic       MEM_RDEN1;
    logic       MEM_RDEN2;
    logic       CSR_WE;
    logic       INT_TAKEN;
    logic       ILLEGAL;
    logic [2:0] STATE;
    modport master (
        input  IR_OPCODE, IR_FUNC3, INTR, CSR_MIE, MEM_RDY,
        output PC_WRITE, REG_WRITE, MEM_WE2, MEM_RDEN1, MEM_RDEN2, CSR_WE, INT_TAKEN, ILLEGAL, STATE
    );
    modport slave (
        output IR_OPCODE, IR_FUNC3, INTR, CSR_MIE, MEM_RDY,
        input  PC_WRITE, REG_WRITE, MEM_WE2, MEM_RDEN1, MEM_RDEN2, CSR_WE, INT_TAKEN, ILLEGAL, STATE
    );
endinterface

// File: rtl/otter_cu_fsm.sv
// otter_cu_fsm: OTTER multicycle control unit (INIT/FETCH/EXEC/WB/INTR state machine)
//   CLK   rising-edge clock
//   RST_N asynchronous active-low reset, forces INIT and all strobes low
//   cu    otter_cu_fsm_if.master: instruction fields, interrupt inputs, datapath strobes, STATE
//   Define CU_MEM_WAIT_EN to route loads/stores through a MEM_WAIT state gated by MEM_RDY.
module otter_cu_fsm
    import otter_cu_pkg::*;
(
    input  logic          CLK,
    input  logic          RST_N,
    otter_cu_fsm_if.master cu
);
    state_t state_q, state_d;
    logic   int_pend;
    assign int_pend = cu.INTR & cu.CSR_MIE;
    assign cu.STATE = state_q;
`ifndef CU_MEM_WAIT_EN
    logic unused_mem_rdy;
    assign unused_mem_rdy = cu.MEM_RDY;
`endif
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) state_q <= ST_INIT;
        else        state_q <= state_d;
    // Strobes are decoded from state_q, so asserting reset clears them without a clock.
    always_comb begin
        state_d      = state_q;
        cu.PC_WRITE  = 1'b0;
        cu.REG_WRITE = 1'b0;
        cu.MEM_WE2   = 1'b0;
        cu.MEM_RDEN1 = 1'b0;
        cu.MEM_RDEN2 = 1'b0;
        cu.CSR_WE    = 1'b0;
        cu.INT_TAKEN = 1'b0;
        cu.ILLEGAL   = 1'b0;
        case (state_q)
            ST_INIT:  state_d = ST_FETCH;
            ST_FETCH: begin
                cu.MEM_RDEN1 = 1'b1;
                state_d      = ST_EXEC;
            end
            ST_EXEC: begin
                cu.PC_WRITE = 1'b1;
                state_d     = int_pend ? ST_INTR : ST_FETCH;
                case (cu.IR_OPCODE)
                    OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: cu.REG_WRITE = 1'b1;
                    OPC_BRANCH: ;
                    OPC_STORE: begin
                        cu.MEM_WE2 = 1'b1;
`ifdef CU_MEM_WAIT_EN
                        cu.PC_WRITE = 1'b0;
                        state_d     = ST_MEM_WAIT;
`endif
                    end
                    OPC_LOAD: begin
                        cu.MEM_RDEN2 = 1'b1;
                        cu.PC_WRITE  = 1'b0;
`ifdef CU_MEM_WAIT_EN
                        state_d = ST_MEM_WAIT;
`else
                        state_d = ST_WB;
`endif
                    end
                    OPC_SYSTEM: begin
                        cu.REG_WRITE = cu.IR_FUNC3 == F3_CSRRW;
                        cu.CSR_WE    = cu.IR_FUNC3 == F3_CSRRW;
                        cu.ILLEGAL   = cu.IR_FUNC3 != F3_CSRRW && cu.IR_FUNC3 != F3_MRET;
                    end
                    default: cu.ILLEGAL = 1'b1;
                endcase
            end
            ST_WB: begin
                cu.REG_WRITE = 1'b1;
                cu.PC_WRITE  = 1'b1;
                state_d      = int_pend ? ST_INTR : ST_FETCH;
            end
            ST_INTR: begin
                cu.INT_TAKEN = 1'b1;
                cu.PC_WRITE  = 1'b1;
                state_d      = ST_FETCH;
            end
`ifdef CU_MEM_WAIT_EN
            // IR is still valid here, so it tells load from store without extra state.
            ST_MEM_WAIT: begin
                if (cu.IR_OPCODE == OPC_LOAD) begin
                    cu.MEM_RDEN2 = 1'b1;
                    state_d      = cu.MEM_RDY ? ST_WB : ST_MEM_WAIT;
                end else begin
                    cu.MEM_WE2  = 1'b1;
                    cu.PC_WRITE = cu.MEM_RDY;
                    state_d     = !cu.MEM_RDY ? ST_MEM_WAIT : int_pend ? ST_INTR : ST_FETCH;
                end
            end
`endif
            default: state_d = ST_INIT;
        endcase
    end
endmodule

// File: tb/tb_otter_cu_fsm.sv
// tb_otter_cu_fsm: scoreboard bench for otter_cu_fsm with randomized instruction stream
`timescale 1ns/1ps
module tb_otter_cu_fsm;
    import otter_cu_pkg::*;
    typedef logic [10:0] vec_t;
    localparam logic [7:0] B_PC = 8'h80, B_RW = 8'h40, B_W2 = 8'h20, B_R1 = 8'h10;
    localparam logic [7:0] B_R2 = 8'h08, B_CS = 8'h04, B_IT = 8'h02, B_IL = 8'h01;
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    otter_cu_fsm_if bus();
    otter_cu_fsm dut (.CLK(CLK), .RST_N(RST_N), .cu(bus));
    always #5 CLK = ~CLK;
    vec_t  exp_q[$];
    string name_q[$];
    int    n_chk = 0;
    int    n_fail = 0;
    function automatic vec_t mk(input state_t s, input logic [7:0] b);
        return {s, b};
    endfunction
    function automatic vec_t got();
        return {bus.STATE, bus.PC_WRITE, bus.REG_WRITE, bus.MEM_WE2, bus.MEM_RDEN1,
                bus.MEM_RDEN2, bus.CSR_WE, bus.INT_TAKEN, bus.ILLEGAL};
    endfunction
    task automatic check(input vec_t e, input string nm);
        vec_t g;
        g = got();
        n_chk++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL %s: got state=%0d strobes=%b, expected state=%0d strobes=%b",
                     nm, g[10:8], g[7:0], e[10:8], e[7:0]);
        end
    endtask
    // Monitor: every cycle while out of reset has an expectation queued; in reset all must be 0.
    initial forever begin
        @(negedge CLK);
        if (exp_q.size() > 0) check(exp_q.pop_front(), name_q.pop_front());
        else if (!RST_N) check(mk(ST_INIT, 8'h00), "reset");
    end
    task automatic release_reset();
        RST_N = 1'b1;
        exp_q.push_back(mk(ST_INIT, 8'h00));
        name_q.push_back("init");
        @(posedge CLK); #1;
    endtask
    // Reference: expand one instruction into its per-cycle strobe pattern, then play it out.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic intr,
                             input logic mie, input int w, input int rst_at, input string nm);
        vec_t seq[$];
        logic rdy[$];
        logic alu, br, ld, st, csrw, mret;
        alu  = op inside {OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR};
        br   = op == OPC_BRANCH;
        ld   = op == OPC_LOAD;
        st   = op == OPC_STORE;
        csrw = op == OPC_SYSTEM && f3 == F3_CSRRW;
        mret = op == OPC_SYSTEM && f3 == F3_MRET;
        seq.push_back(mk(ST_FETCH, B_R1));
        if (ld) begin
            seq.push_back(mk(ST_EXEC, B_R2));
`ifdef CU_MEM_WAIT_EN
            for (int i = 0; i <= w; i++) seq.push_back(mk(ST_MEM_WAIT, B_R2));
`endif
            seq.push_back(mk(ST_WB, B_PC | B_RW));
        end else if (st) begin
`ifdef CU_MEM_WAIT_EN
            seq.push_back(mk(ST_EXEC, B_W2));
            for (int i = 0; i < w; i++) seq.push_back(mk(ST_MEM_WAIT, B_W2));
            seq.push_back(mk(ST_MEM_WAIT, B_W2 | B_PC));
`else
            seq.push_back(mk(ST_EXEC, B_W2 | B_PC));
`endif
        end else
            seq.push_back(mk(ST_EXEC, B_PC | (alu ? B_RW : 8'h00) | (csrw ? B_RW | B_CS : 8'h00)
                                     | (!alu && !br && !csrw && !mret ? B_IL : 8'h00)));
        if (intr && mie) seq.push_back(mk(ST_INTR, B_PC | B_IT));
        for (int i = 0; i < seq.size(); i++) begin
`ifdef CU_MEM_WAIT_EN
            rdy.push_back(i == 2 + w);
`else
            rdy.push_back(1'($urandom));
`endif
        end
        bus.IR_OPCODE = op;
        bus.IR_FUNC3  = f3;
        bus.INTR      = intr;
        bus.CSR_MIE   = mie;
        for (int i = 0; i < seq.size(); i++) begin
            if (i == rst_at) begin
                RST_N = 1'b0;
                repeat (2) begin @(posedge CLK); #1; end
                release_reset();
                return;
            end
            bus.MEM_RDY = rdy[i];
            exp_q.push_back(seq[i]);
            name_q.push_back(nm);
            @(posedge CLK); #1;
        end
    endtask
    logic [6:0] ops[12];
    initial begin
        ops = '{OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                OPC_STORE, OPC_LOAD, OPC_SYSTEM, 7'b1111111, 7'b0000000};
        bus.IR_OPCODE = OPC_OP;
        bus.IR_FUNC3  = 3'd0;
        bus.INTR      = 1'b0;
        bus.CSR_MIE   = 1'b0;
        bus.MEM_RDY   = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end
        release_reset();
        run_instr(OPC_OP, 3'd0, 1'b0, 1'b0, 0, -1, "alu");
        run_instr(OPC_LOAD, 3'd2, 1'b0, 1'b0, 3, -1, "load");
        run_instr(OPC_STORE, 3'd2, 1'b1, 1'b1, 1, -1, "store_int");
        run_instr(OPC_STORE, 3'd2, 1'b1, 1'b0, 0, -1, "store_nomie");
        run_instr(7'b1111111, 3'd0, 1'b0, 1'b1, 0, -1, "illegal");
        run_instr(OPC_SYSTEM, F3_MRET, 1'b1, 1'b1, 0, -1, "mret_int");
        run_instr(OPC_SYSTEM, F3_CSRRW, 1'b1, 1'b0, 0, -1, "csrrw");
        run_instr(OPC_SYSTEM, 3'b010, 1'b0, 1'b0, 0, -1, "sys_bad");
        run_instr(OPC_BRANCH, 3'd0, 1'b1, 1'b1, 0, -1, "branch_int");
        run_instr(OPC_LOAD, 3'd0, 1'b1, 1'b1, 0, -1, "load_int");
        run_instr(OPC_LOAD, 3'd0, 1'b0, 1'b0, 3, 2, "load_rst");
        run_instr(OPC_JAL, 3'd0, 1'b0, 1'b0, 0, 1, "exec_rst");
        for (int n = 0; n < 400; n++) begin
            int idx;
            logic [6:0] op;
            idx = $urandom_range(0, 12);
            op  = idx == 12 ? 7'($urandom) : ops[idx];
            run_instr(op, 3'($urandom_range(0, 2)), 1'($urandom), 1'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 19) == 0 ? $urandom_range(1, 3) : -1, "random");
        end
        @(negedge CLK); #1;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
